// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. It issues reads to a multi-cycle
// memory, updates the PC and holds one fetched instruction for decode.
// Branch redirects squash in-flight reads, and memory errors lock the block
// until reset.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        br_tkn,
  input  logic [15:0] br_target,
  input  logic        stall_in,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  input  logic        mem_err,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        pc_we,
  output logic [15:0] pc_next,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_pc_plus,
  output logic        instr_valid,
  output logic        err
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_instr_valid;
  logic [15:0] r_instr_out;
  logic [15:0] r_instr_pc;
  logic [15:0] r_instr_pc_plus;
  logic        r_err;

  logic        w_slot_free;
  logic [15:0] w_pc_plus2;
  logic        w_load;
  logic        w_flush;
  logic        w_err_hit;

  // The buffer can take a new word if it is empty or is drained this cycle.
  assign w_slot_free = !r_instr_valid || !stall_in;
  // 16-bit add wraps naturally, so 16'hFFFE + 2 gives 16'h0000.
  assign w_pc_plus2  = pc + 16'd2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, memory request and PC update. mem_err beats br_tkn and mem_done.
  always_comb begin
    w_state_nxt = r_state;
    mem_rd      = 1'b0;
    mem_addr    = pc;
    pc_we       = 1'b0;
    pc_next     = pc;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    w_err_hit   = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (mem_err) begin
            // A read may already be issued when the error arrives.
            // It is left alone, because the block stops here anyway.
            mem_rd      = w_slot_free && !mem_stall && !br_tkn;
            w_err_hit   = 1'b1;
            w_state_nxt = ERR;
          end else if (br_tkn) begin
            pc_we   = 1'b1;
            pc_next = br_target;
            w_flush = 1'b1;
          end else if (w_slot_free && !mem_stall) begin
            mem_rd = 1'b1;
            if (mem_done) begin
              w_load  = 1'b1;
              pc_we   = 1'b1;
              pc_next = w_pc_plus2;
            end else begin
              w_state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_err) begin
            w_err_hit   = 1'b1;
            w_state_nxt = ERR;
          end else if (br_tkn) begin
            pc_we       = 1'b1;
            pc_next     = br_target;
            w_flush     = 1'b1;
            w_state_nxt = mem_done ? IDLE : SQUASH;
          end else if (mem_done) begin
            w_load      = 1'b1;
            pc_we       = 1'b1;
            pc_next     = w_pc_plus2;
            w_state_nxt = IDLE;
          end
        end
        SQUASH: begin
          if (mem_err) begin
            w_err_hit   = 1'b1;
            w_state_nxt = ERR;
          end else begin
            if (br_tkn) begin
              pc_we   = 1'b1;
              pc_next = br_target;
              w_flush = 1'b1;
            end
            if (mem_done) w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = ERR;
        end
      endcase
    end
  end

  // Instruction buffer. An error or a flush beats a reload, and a reload
  // beats a consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_out     <= NOP;
      r_instr_pc      <= 16'h0000;
      r_instr_pc_plus <= 16'h0000;
      r_instr_valid   <= 1'b0;
    end else if (w_err_hit || w_flush) begin
      r_instr_out   <= NOP;
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr_out     <= mem_data;
      r_instr_pc      <= pc;
      r_instr_pc_plus <= w_pc_plus2;
      r_instr_valid   <= 1'b1;
    end else if (r_instr_valid && !stall_in) begin
      r_instr_out   <= NOP;
      r_instr_valid <= 1'b0;
    end
  end

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_hit) r_err <= 1'b1;
  end

  assign instr_out     = r_instr_out;
  assign instr_pc      = r_instr_pc;
  assign instr_pc_plus = r_instr_pc_plus;
  assign instr_valid   = r_instr_valid;
  assign err           = r_err;

endmodule
